// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its bus-conditioning front end.
// Latency: none (declarations only).
// Backpressure: none; the I2C target never stretches SCL.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } i2c_slave_state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA pins and flags SCL edges plus START/STOP conditions.
// Latency: pin change to registered event output is 3 clk.
// Backpressure: none; events are single-cycle pulses that must be consumed when seen.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   scl_i, sda_i      raw asynchronous bus pins
//   scl_p_edge_o      one-cycle pulse on synchronised SCL rising edge
//   scl_n_edge_o      one-cycle pulse on synchronised SCL falling edge
//   start_det_o       SDA 1->0 while SCL high
//   stop_det_o        SDA 0->1 while SCL high
//   sda_sync_o        synchronised SDA, aligned with the event pulses
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_p_edge_o,
  output logic scl_n_edge_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_sync_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;

  // Pipeline resets to the idle-bus level (both lines high) so no false
  // edge or START is reported as reset is released on an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q   <= 2'b11;
      sda_sync_q   <= 2'b11;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      scl_p_edge_o <= 1'b0;
      scl_n_edge_o <= 1'b0;
      start_det_o  <= 1'b0;
      stop_det_o   <= 1'b0;
      sda_sync_o   <= 1'b1;
    end else begin
      scl_sync_q   <= {scl_sync_q[0], scl_i};
      sda_sync_q   <= {sda_sync_q[0], sda_i};
      scl_prev_q   <= scl_sync_q[1];
      sda_prev_q   <= sda_sync_q[1];
      scl_p_edge_o <= scl_sync_q[1] & ~scl_prev_q;
      scl_n_edge_o <= ~scl_sync_q[1] & scl_prev_q;
      // Uses the current SCL level: an SDA change coincident with SCL
      // falling is an ordinary data transition, not a bus condition.
      start_det_o  <= scl_sync_q[1] & sda_prev_q & ~sda_sync_q[1];
      stop_det_o   <= scl_sync_q[1] & ~sda_prev_q & sda_sync_q[1];
      sda_sync_o   <= sda_sync_q[1];
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// I2C target with a pointer-addressed byte register file (write: ptr byte then data; read: from ptr).
// Latency: SCL pin edge to sda_o change is 4 clk; master SCL low time must be >= 6 clk.
// Backpressure: none; the target never stretches SCL, it only ACKs/NACKs.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   scl_i, sda_i      raw asynchronous bus pins
//   sda_o             open-drain SDA control (0 pulls low, 1 releases)
//   regs_o            register file, regs[i] at bits [8i+7:8i]
//   wr_strobe/wr_idx  one-cycle pulse and index when a data byte is committed
//   busy              high from address match until STOP, NACK exit or mismatch
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 4,
  localparam int        PW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  wr_strobe,
  output logic [PW-1:0]         wr_idx,
  output logic                  busy
);

  logic p_edge, n_edge, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .scl_p_edge_o (p_edge),
    .scl_n_edge_o (n_edge),
    .start_det_o  (start_det),
    .stop_det_o   (stop_det),
    .sda_sync_o   (sda_s)
  );

  i2c_slave_state_t            state_q, state_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic [7:0]                  shift_q, shift_d;
  logic [PW-1:0]               ptr_q, ptr_d;
  logic                        sda_q, sda_d;
  logic                        busy_q, busy_d;
  logic                        rw_q, rw_d;
  logic                        first_q, first_d;  // next written byte is the pointer byte
  logic                        ack_q, ack_d;      // ACK phase sub-step (see ADDR_ACK/WR_ACK/RD_ACK)
  logic [NUM_REGS-1:0][7:0]    regs_q, regs_d;
  logic                        wr_strobe_q, wr_strobe_d;
  logic [PW-1:0]               wr_idx_q, wr_idx_d;
  logic [7:0]                  rx_byte;

  // Byte as it stands once the current p_edge bit is shifted in.
  assign rx_byte = {shift_q[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_q       <= 1'b1;
      busy_q      <= 1'b0;
      rw_q        <= RW_WRITE;
      first_q     <= 1'b0;
      ack_q       <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_q       <= sda_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      ack_q       <= ack_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_idx_q    <= wr_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_d       = sda_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    first_d     = first_q;
    ack_d       = ack_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_idx_d    = wr_idx_q;

    if (stop_det) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
      ack_d   = 1'b0;
    end else if (start_det) begin
      // Pointer deliberately kept so a repeated START can read from it.
      state_d = ADDR;
      cnt_d   = '0;
      sda_d   = 1'b1;
      ack_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, WAIT_STOP: ;

        ADDR: if (p_edge) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = rx_byte[0];
            end else begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end
          end
        end

        // First n_edge (end of 8th bit clock) starts the ACK; second n_edge
        // (end of ACK clock) leaves the ACK slot.
        ADDR_ACK: if (n_edge) begin
          if (!ack_q) begin
            sda_d = ACK;
            ack_d = 1'b1;
          end else begin
            ack_d = 1'b0;
            cnt_d = '0;
            if (rw_q == RW_WRITE) begin
              state_d = WR_BYTE;
              sda_d   = 1'b1;
              first_d = 1'b1;
            end else begin
              state_d = RD_BYTE;
              shift_d = regs_q[ptr_q];
              sda_d   = regs_q[ptr_q][7];
              ptr_d   = ptr_q + PW'(1);
            end
          end
        end

        WR_BYTE: if (p_edge) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = WR_ACK;
            if (first_q) begin
              ptr_d   = rx_byte[PW-1:0];
              first_d = 1'b0;
            end else begin
              regs_d[ptr_q] = rx_byte;
              wr_strobe_d   = 1'b1;
              wr_idx_d      = ptr_q;
              ptr_d         = ptr_q + PW'(1);
            end
          end
        end

        WR_ACK: if (n_edge) begin
          if (!ack_q) begin
            sda_d = ACK;
            ack_d = 1'b1;
          end else begin
            ack_d   = 1'b0;
            cnt_d   = '0;
            state_d = WR_BYTE;
            sda_d   = 1'b1;
          end
        end

        // MSB already on the line at load; n_edges 1..7 shift out bits 6..0,
        // the 8th releases SDA for the master's ACK/NACK.
        RD_BYTE: if (n_edge) begin
          if (cnt_q == 3'd7) begin
            state_d = RD_ACK;
            sda_d   = 1'b1;
            ack_d   = 1'b0;
          end else begin
            sda_d   = shift_q[6];
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + 3'd1;
          end
        end

        // ack_q records a master ACK seen on p_edge; the following n_edge
        // loads the next byte.
        RD_ACK: begin
          if (p_edge) begin
            if (sda_s == NACK) begin
              state_d = WAIT_STOP;
              busy_d  = 1'b0;
            end else begin
              ack_d = 1'b1;
            end
          end else if (n_edge && ack_q) begin
            ack_d   = 1'b0;
            cnt_d   = '0;
            state_d = RD_BYTE;
            shift_d = regs_q[ptr_q];
            sda_d   = regs_q[ptr_q][7];
            ptr_d   = ptr_q + PW'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_o     = sda_q;
  assign regs_o    = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_idx    = wr_idx_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged master on an open-drain bus model.
// Latency: SCL quarter period Q clk; each bit is 4*Q clk.
// Backpressure: none; the bench never waits on the DUT, all delays are fixed.
module tb_i2c_slave;

  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_scl, m_sda;
  logic        bus_sda;
  logic        sda_o;
  logic [31:0] regs_o;
  logic        wr_strobe;
  logic [1:0]  wr_idx;
  logic        busy;

  assign bus_sda = m_sda & sda_o;

  i2c_slave #(.SLAVE_ADDR(7'h50), .NUM_REGS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (m_scl),
    .sda_i     (bus_sda),
    .sda_o     (sda_o),
    .regs_o    (regs_o),
    .wr_strobe (wr_strobe),
    .wr_idx    (wr_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         strobe_cnt = 0;
  int         sda_low_cnt = 0;
  int         busy_cnt = 0;
  logic [1:0] idx_log [$];

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt++;
      idx_log.push_back(wr_idx);
    end
    if (!sda_o) sda_low_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock; returns sda_o sampled mid-high.
  task automatic scl_bit(input logic b, output logic smp);
    tick(Q); m_sda = b;
    tick(Q); m_scl = 1'b1;
    tick(Q); smp = sda_o;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic do_start;
    tick(Q); m_sda = 1'b1;
    tick(Q); m_scl = 1'b1;
    tick(Q); m_sda = 1'b0;
    tick(Q); m_scl = 1'b0;
  endtask

  task automatic do_stop;
    tick(Q); m_sda = 1'b0;
    tick(Q); m_scl = 1'b1;
    tick(Q); m_sda = 1'b1;
    tick(2 * Q);
  endtask

  // r = {SDA released through all data bits, sda_o in the ACK slot}
  task automatic wr_byte(input logic [7:0] b, output logic [1:0] r);
    logic s;
    logic rel;
    rel = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      scl_bit(b[i], s);
      rel = rel & s;
    end
    scl_bit(1'b1, s);
    r = {rel, s};
  endtask

  // r = {data byte driven by the target, sda_o during the master ACK slot}
  task automatic rd_byte(input logic mack, output logic [8:0] r);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      scl_bit(1'b1, s);
      r[i + 1] = s;
    end
    scl_bit(mack, s);
    r[0] = s;
  endtask

  logic [1:0] a;
  logic [8:0] rd;
  logic       s;
  logic       rel;
  int         s0, l0, b0;

  initial begin
    rst   = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    tick(4);
    check("rst_sda_o",     32'(sda_o),     32'h1);
    check("rst_regs",      regs_o,         32'h0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    check("rst_wr_idx",    32'(wr_idx),    32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    rst = 1'b0;
    tick(4 * Q);

    // Write with auto-increment
    s0 = strobe_cnt;
    do_start;
    wr_byte(8'hA0, a); check("w1_addr_ack", 32'(a), 32'h2);
    check("w1_busy", 32'(busy), 32'h1);
    wr_byte(8'h01, a); check("w1_ptr_ack",  32'(a), 32'h2);
    wr_byte(8'hA5, a); check("w1_d0_ack",   32'(a), 32'h2);
    wr_byte(8'h3C, a); check("w1_d1_ack",   32'(a), 32'h2);
    check("w1_busy_pre_stop", 32'(busy), 32'h1);
    do_stop;
    check("w1_busy_post_stop", 32'(busy), 32'h0);
    check("w1_regs", regs_o, 32'h003CA500);
    check("w1_strobes", 32'(strobe_cnt - s0), 32'd2);
    check("w1_idx0", 32'(idx_log[s0]),     32'd1);
    check("w1_idx1", 32'(idx_log[s0 + 1]), 32'd2);

    // Wrong address
    s0 = strobe_cnt; l0 = sda_low_cnt; b0 = busy_cnt;
    do_start;
    wr_byte(8'hA2, a); check("wa_addr_nack", 32'(a), 32'h3);
    wr_byte(8'h00, a); check("wa_b1_nack",   32'(a), 32'h3);
    wr_byte(8'hFF, a); check("wa_b2_nack",   32'(a), 32'h3);
    do_stop;
    check("wa_sda_low_cycles", 32'(sda_low_cnt - l0), 32'd0);
    check("wa_strobes",        32'(strobe_cnt - s0),  32'd0);
    check("wa_busy_cycles",    32'(busy_cnt - b0),    32'd0);
    check("wa_regs", regs_o, 32'h003CA500);

    // Preload {11,22,33,44} (pointer wraps back to 0)
    do_start;
    wr_byte(8'hA0, a);
    wr_byte(8'h00, a);
    wr_byte(8'h11, a);
    wr_byte(8'h22, a);
    wr_byte(8'h33, a);
    wr_byte(8'h44, a); check("pre_last_ack", 32'(a), 32'h2);
    do_stop;
    check("pre_regs", regs_o, 32'h44332211);

    // Repeated-start read with wrap
    do_start;
    wr_byte(8'hA0, a); check("rd_waddr_ack", 32'(a), 32'h2);
    wr_byte(8'h03, a); check("rd_ptr_ack",   32'(a), 32'h2);
    do_start;
    wr_byte(8'hA1, a); check("rd_raddr_ack", 32'(a), 32'h2);
    rd_byte(1'b0, rd); check("rd_byte0_ack_slot", 32'(rd), {23'd0, 8'h44, 1'b1});
    rd_byte(1'b1, rd); check("rd_byte1_nack_slot", 32'(rd), {23'd0, 8'h11, 1'b1});
    tick(Q);
    check("rd_sda_after_nack",  32'(sda_o), 32'h1);
    check("rd_busy_after_nack", 32'(busy),  32'h0);
    do_stop;

    // STOP mid-byte
    s0 = strobe_cnt;
    do_start;
    wr_byte(8'hA0, a);
    wr_byte(8'h00, a); check("ms_ptr_ack", 32'(a), 32'h2);
    rel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      scl_bit(1'b1, s);
      rel = rel & s;
    end
    check("ms_partial_released", 32'(rel), 32'h1);
    do_stop;
    check("ms_strobes", 32'(strobe_cnt - s0), 32'd0);
    check("ms_busy",    32'(busy),  32'h0);
    check("ms_sda",     32'(sda_o), 32'h1);
    check("ms_regs",    regs_o, 32'h44332211);
    do_start;
    wr_byte(8'hA0, a);
    wr_byte(8'h00, a);
    wr_byte(8'h77, a); check("ms_fresh_ack", 32'(a), 32'h2);
    do_stop;
    check("ms_fresh_regs", regs_o, 32'h44332277);
    check("ms_fresh_idx",  32'(idx_log[s0]), 32'd0);

    // Write wrap
    s0 = strobe_cnt;
    do_start;
    wr_byte(8'hA0, a);
    wr_byte(8'h03, a);
    wr_byte(8'h01, a);
    wr_byte(8'h02, a); check("ww_last_ack", 32'(a), 32'h2);
    do_stop;
    check("ww_regs", regs_o, 32'h01332202);
    check("ww_idx0", 32'(idx_log[s0]),     32'd3);
    check("ww_idx1", 32'(idx_log[s0 + 1]), 32'd0);

    // Reset while the target drives a 0 data bit (regs[0]=0x02, MSB 0)
    do_start;
    wr_byte(8'hA0, a);
    wr_byte(8'h00, a);
    do_start;
    wr_byte(8'hA1, a); check("rr_addr_ack", 32'(a), 32'h2);
    tick(Q);
    check("rr_driving_zero", 32'(sda_o), 32'h0);
    rst = 1'b1;
    tick(1);
    check("rr_sda_released", 32'(sda_o), 32'h1);
    check("rr_regs",         regs_o,     32'h0);
    check("rr_busy",         32'(busy),  32'h0);
    rst   = 1'b0;
    m_sda = 1'b1;
    m_scl = 1'b1;
    tick(4 * Q);
    check("rr_idle_sda", 32'(sda_o), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
